reservation_station: RTL and testbench
======================================

// Module: reservation_station
// PURPOSE
// - Generic issue-queue responder on the res_i issue side; one instance each for int/mud/bra/mem queues.
// - Accepts dispatched entries and tracks source-operand readiness via CDB tag wakeup.
// - Presents per-slot req/euid vectors to issue-stage select logic and returns the selected entry.
// - Frees the issued slot on the next clock edge.
// PARAMETERS
// - DEPTH       8   entries; maps to INT/MUD/BR/MEM_ISSUE_DEPTH in backend_types.
// - NUM_CDB     2   CDB broadcast ports checked each cycle.
// - PTAG_W      6   physical register tag width (matches prs1_addr/prs2_addr).
// - EUID_W      $clog2(NUM_EU)   execution-unit id width.
// PORTS
// - clk                 in   1                    clock, rising edge
// - rst_n               in   1                    asynchronous reset, active-low
// - flush               in   1                    squash all entries (mispredict recovery)
// - dispatch_valid      in   1                    write dispatch_entry this cycle
// - dispatch_entry      in   res_entry_t          ctrl/meta/rvfi bundle
// - dispatch_rs1_ready  in   1                    prs1 ready per busy table at dispatch
// - dispatch_rs2_ready  in   1                    prs2 ready per busy table at dispatch
// - dispatch_euid       in   EUID_W               target EU for this entry
// - full                out  1                    all DEPTH slots valid
// - empty               out  1                    no slot valid
// - req                 out  DEPTH                slot valid & both operands ready
// - euid                out  DEPTH x EUID_W       per-slot target EU
// - ren                 in   1                    issue stage takes slot raddr this cycle
// - raddr               in   $clog2(DEPTH)        slot selected by issue
// - rdata               out  res_entry_t          entry[raddr], combinational
// - cdb_valid           in   NUM_CDB              CDB broadcast valid
// - cdb_ptag            in   NUM_CDB x PTAG_W     destination tag being written back
// BEHAVIOUR
// - Reset (rst_n=0, async): all valid/rdy1/rdy2 bits cleared; req=0, full=0, empty=1; payload not reset.
// - Slot state: valid, rdy1, rdy2, euid, entry; next-state held in flops, outputs derived combinationally.
// - Dispatch
//   - Accepted iff dispatch_valid & ~full.
//   - Written into lowest-index invalid slot; valid=1 at the next edge.
//   - dispatch_valid while full: dropped; illegal, flagged by assertion.
// - Operand ready at dispatch = dispatch_rsN_ready | (prsN==0) | CDB hit on prsN this cycle (same-cycle bypass).
// - Wakeup: each cycle, a valid slot with a nonzero prsN matching any cdb_valid[k]/cdb_ptag[k] sets rdyN.
//   - rdyN is sticky until the slot frees.
// - req[i] = valid[i] & rdy1[i] & rdy2[i], from registered state only.
//   - A CDB hit raises req one cycle later.
// - Issue
//   - rdata = entry[raddr] every cycle, regardless of ren.
//   - ren=1: valid[raddr] clears at the next edge; req[raddr] is 0 the following cycle.
//   - ren with req[raddr]=0 is illegal (assertion); state unchanged.
// - Issue + dispatch, same cycle: both honoured.
//   - The freed slot is NOT reusable for that dispatch; full is evaluated on pre-issue state.
// - full/empty: combinational from current valid vector; no lookahead.
// - flush: clears every valid at the next edge; takes priority over dispatch, issue and wakeup that cycle.
// - Ordering: no age order; the issue stage selects the lowest index.
// STRUCTURE
// - backend_types holds res_entry_t, NUM_EU, the *_ISSUE_DEPTH constants and the euid enum; no new typedefs here.
// - One sub-module: rs_wakeup_cmp (ptag vs NUM_CDB tags -> hit), instantiated 2x per slot plus 2x for dispatch bypass.
// - Free-slot select: priority encoder inline.
// TESTING
// - Reset: rst_n low mid-operation with 3 valid slots -> same cycle req=0, empty=1, full=0.
// - Dispatch ready: dispatch prs1=5, prs2=0, rs1_ready=1 -> next cycle slot0 valid, req[0]=1, rdata.meta.prs1_addr=5 with raddr=0.
// - Wakeup
//   - Dispatch prs1=9 not ready -> req[0]=0.
//   - cdb_valid[1]=1, ptag=9 -> req[0]=1 next cycle.
//   - Also cover the same-cycle dispatch/CDB bypass.
// - Full/simultaneous
//   - Fill 8 slots -> full=1.
//   - ren raddr=3 plus dispatch the same cycle -> dispatch dropped (assert fires), slot3 freed.
//   - Next dispatch lands in slot3.
// - Flush: flush=1 with dispatch_valid=1 and ren=1 -> next cycle all valid=0, empty=1.
// - Issue-dispatch: 2 entries, ren raddr=0 while dispatching -> new entry lands in slot2 (lowest free), slot0 free after.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared backend types for the issue queues: entry payload, EU ids and queue depths.
package reservation_station_pkg;

  localparam int unsigned NUM_EU          = 4;
  localparam int unsigned PHYS_TAG_W      = 6;
  localparam int unsigned INT_ISSUE_DEPTH = 8;
  localparam int unsigned MUD_ISSUE_DEPTH = 8;
  localparam int unsigned BR_ISSUE_DEPTH  = 8;
  localparam int unsigned MEM_ISSUE_DEPTH = 8;

  typedef enum logic [1:0] {EuAlu, EuMud, EuBru, EuMem} euid_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] imm;
  } res_ctrl_t;

  typedef struct packed {
    logic [PHYS_TAG_W-1:0] prs1_addr;
    logic [PHYS_TAG_W-1:0] prs2_addr;
    logic [PHYS_TAG_W-1:0] prd_addr;
  } res_meta_t;

  typedef struct packed {
    logic [31:0] pc;
  } res_rvfi_t;

  typedef struct packed {
    res_ctrl_t ctrl;
    res_meta_t meta;
    res_rvfi_t rvfi;
  } res_entry_t;

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch and issue-select bundle between the backend and one reservation station.
interface reservation_station_if
  import reservation_station_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned EUID_W = 2
) ();

  logic                         dispatch_valid;
  res_entry_t                   dispatch_entry;
  logic                         dispatch_rs1_ready;
  logic                         dispatch_rs2_ready;
  logic [EUID_W-1:0]            dispatch_euid;
  logic                         full;
  logic                         empty;
  logic [DEPTH-1:0]             req;
  logic [DEPTH-1:0][EUID_W-1:0] euid;
  logic                         ren;
  logic [$clog2(DEPTH)-1:0]     raddr;
  res_entry_t                   rdata;

  modport master (
    output dispatch_valid, dispatch_entry, dispatch_rs1_ready, dispatch_rs2_ready,
    output dispatch_euid, ren, raddr,
    input  full, empty, req, euid, rdata
  );

  modport slave (
    input  dispatch_valid, dispatch_entry, dispatch_rs1_ready, dispatch_rs2_ready,
    input  dispatch_euid, ren, raddr,
    output full, empty, req, euid, rdata
  );

endinterface

// File: rtl/rs_wakeup_cmp.sv
// Compares one source tag against all CDB broadcasts; tag 0 never hits.
module rs_wakeup_cmp #(
  parameter int unsigned NUM_CDB = 2,
  parameter int unsigned PTAG_W  = 6
) (
  input  logic [PTAG_W-1:0]              ptag,
  input  logic [NUM_CDB-1:0]             cdb_valid,
  input  logic [NUM_CDB-1:0][PTAG_W-1:0] cdb_ptag,
  output logic                           hit
);

  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_valid[k] && (cdb_ptag[k] == ptag)) hit = 1'b1;
    end
    if (ptag == '0) hit = 1'b0;
  end

endmodule

// File: rtl/reservation_station.sv
// Unordered issue queue: holds dispatched entries until both sources are woken by the CDB.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned DEPTH   = INT_ISSUE_DEPTH,
  parameter int unsigned NUM_CDB = 2,
  parameter int unsigned PTAG_W  = PHYS_TAG_W,
  parameter int unsigned EUID_W  = $clog2(NUM_EU)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic [NUM_CDB-1:0]             cdb_valid,
  input  logic [NUM_CDB-1:0][PTAG_W-1:0] cdb_ptag,
  reservation_station_if.slave           rs
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0]             rdy1_q, rdy1_d;
  logic [DEPTH-1:0]             rdy2_q, rdy2_d;
  logic [DEPTH-1:0]             hit1, hit2, req_w;
  res_entry_t                   entry_q [DEPTH];
  logic [DEPTH-1:0][EUID_W-1:0] euid_q;

  logic             full_w;
  logic             dispatch_accept;
  logic [IDX_W-1:0] free_idx;
  logic             disp_hit1, disp_hit2;
  logic             disp_rdy1, disp_rdy2;
  logic             issue_take;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    rs_wakeup_cmp #(.NUM_CDB(NUM_CDB), .PTAG_W(PTAG_W)) u_cmp1 (
      .ptag      (entry_q[i].meta.prs1_addr),
      .cdb_valid (cdb_valid),
      .cdb_ptag  (cdb_ptag),
      .hit       (hit1[i])
    );
    rs_wakeup_cmp #(.NUM_CDB(NUM_CDB), .PTAG_W(PTAG_W)) u_cmp2 (
      .ptag      (entry_q[i].meta.prs2_addr),
      .cdb_valid (cdb_valid),
      .cdb_ptag  (cdb_ptag),
      .hit       (hit2[i])
    );
  end

  // Same-cycle bypass: a tag broadcast while its consumer dispatches.
  rs_wakeup_cmp #(.NUM_CDB(NUM_CDB), .PTAG_W(PTAG_W)) u_disp_cmp1 (
    .ptag      (rs.dispatch_entry.meta.prs1_addr),
    .cdb_valid (cdb_valid),
    .cdb_ptag  (cdb_ptag),
    .hit       (disp_hit1)
  );
  rs_wakeup_cmp #(.NUM_CDB(NUM_CDB), .PTAG_W(PTAG_W)) u_disp_cmp2 (
    .ptag      (rs.dispatch_entry.meta.prs2_addr),
    .cdb_valid (cdb_valid),
    .cdb_ptag  (cdb_ptag),
    .hit       (disp_hit2)
  );

  assign disp_rdy1 = rs.dispatch_rs1_ready | (rs.dispatch_entry.meta.prs1_addr == '0) | disp_hit1;
  assign disp_rdy2 = rs.dispatch_rs2_ready | (rs.dispatch_entry.meta.prs2_addr == '0) | disp_hit2;

  assign req_w           = valid_q & rdy1_q & rdy2_q;
  assign full_w          = &valid_q;
  assign dispatch_accept = rs.dispatch_valid & ~full_w;
  assign issue_take      = rs.ren & req_w[rs.raddr];

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  // Free slot comes from pre-issue state, so an issued slot is never refilled the same cycle.
  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q | (valid_q & hit1);
    rdy2_d  = rdy2_q | (valid_q & hit2);
    if (issue_take) valid_d[rs.raddr] = 1'b0;
    if (dispatch_accept) begin
      valid_d[free_idx] = 1'b1;
      rdy1_d[free_idx]  = disp_rdy1;
      rdy2_d[free_idx]  = disp_rdy2;
    end
    if (flush) begin
      valid_d = '0;
      rdy1_d  = '0;
      rdy2_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (dispatch_accept) begin
      entry_q[free_idx] <= rs.dispatch_entry;
      euid_q[free_idx]  <= rs.dispatch_euid;
    end
  end

  assign rs.full  = full_w;
  assign rs.empty = ~|valid_q;
  assign rs.req   = req_w;
  assign rs.euid  = euid_q;
  assign rs.rdata = entry_q[rs.raddr];

  a_dispatch_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(rs.dispatch_valid && full_w))
    else $warning("reservation_station: dispatch while full dropped");

  a_issue_not_ready: assert property (@(posedge clk) disable iff (!rst_n)
    !(rs.ren && !req_w[rs.raddr]))
    else $error("reservation_station: issue of a slot that is not requesting");

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: dispatch, wakeup, bypass, full, flush and issue.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [1:0]       cdb_valid;
  logic [1:0][5:0]  cdb_ptag;
  int               checks;
  int               failures;

  reservation_station_if #(.DEPTH(8), .EUID_W(2)) rs_bus ();

  reservation_station #(.DEPTH(8), .NUM_CDB(2), .PTAG_W(6), .EUID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .cdb_valid (cdb_valid),
    .cdb_ptag  (cdb_ptag),
    .rs        (rs_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush                     = 1'b0;
    cdb_valid                 = '0;
    cdb_ptag                  = '0;
    rs_bus.dispatch_valid     = 1'b0;
    rs_bus.dispatch_entry     = '0;
    rs_bus.dispatch_rs1_ready = 1'b0;
    rs_bus.dispatch_rs2_ready = 1'b0;
    rs_bus.dispatch_euid      = '0;
    rs_bus.ren                = 1'b0;
    rs_bus.raddr              = '0;
  endtask

  task automatic set_dispatch(input logic [5:0] p1, input logic [5:0] p2,
                              input logic r1, input logic r2, input logic [1:0] eu);
    res_entry_t e;
    e                         = '0;
    e.meta.prs1_addr          = p1;
    e.meta.prs2_addr          = p2;
    e.meta.prd_addr           = p1 + 6'd1;
    e.rvfi.pc                 = {24'h0, 2'b0, p1};
    rs_bus.dispatch_valid     = 1'b1;
    rs_bus.dispatch_entry     = e;
    rs_bus.dispatch_rs1_ready = r1;
    rs_bus.dispatch_rs2_ready = r2;
    rs_bus.dispatch_euid      = eu;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if (rs_bus.req !== 8'h00) begin
      failures++; $display("FAIL reset_req got=%h exp=00", rs_bus.req);
    end
    checks++;
    if (rs_bus.empty !== 1'b1) begin
      failures++; $display("FAIL reset_empty got=%b exp=1", rs_bus.empty);
    end
    checks++;
    if (rs_bus.full !== 1'b0) begin
      failures++; $display("FAIL reset_full got=%b exp=0", rs_bus.full);
    end
  endtask

  task automatic test_dispatch_ready();
    set_dispatch(6'd5, 6'd0, 1'b1, 1'b0, 2'd2);
    cycle();
    idle();
    #1;
    checks++;
    if (rs_bus.req !== 8'h01) begin
      failures++; $display("FAIL disp_req got=%h exp=01", rs_bus.req);
    end
    checks++;
    if (rs_bus.empty !== 1'b0) begin
      failures++; $display("FAIL disp_empty got=%b exp=0", rs_bus.empty);
    end
    checks++;
    if (rs_bus.rdata.meta.prs1_addr !== 6'd5) begin
      failures++; $display("FAIL disp_rdata got=%0d exp=5", rs_bus.rdata.meta.prs1_addr);
    end
    checks++;
    if (rs_bus.euid[0] !== 2'd2) begin
      failures++; $display("FAIL disp_euid got=%0d exp=2", rs_bus.euid[0]);
    end
    rs_bus.ren   = 1'b1;
    rs_bus.raddr = 3'd0;
    cycle();
    idle();
    #1;
    checks++;
    if (rs_bus.req !== 8'h00) begin
      failures++; $display("FAIL issue_req got=%h exp=00", rs_bus.req);
    end
    checks++;
    if (rs_bus.empty !== 1'b1) begin
      failures++; $display("FAIL issue_empty got=%b exp=1", rs_bus.empty);
    end
  endtask

  task automatic test_wakeup();
    set_dispatch(6'd9, 6'd0, 1'b0, 1'b0, 2'd0);
    cycle();
    idle();
    #1;
    checks++;
    if (rs_bus.req !== 8'h00) begin
      failures++; $display("FAIL wake_pre got=%h exp=00", rs_bus.req);
    end
    cdb_valid   = 2'b10;
    cdb_ptag[0] = 6'd7;
    cdb_ptag[1] = 6'd9;
    #1;
    checks++;
    if (rs_bus.req !== 8'h00) begin
      failures++; $display("FAIL wake_same_cycle got=%h exp=00", rs_bus.req);
    end
    cycle();
    idle();
    #1;
    checks++;
    if (rs_bus.req !== 8'h01) begin
      failures++; $display("FAIL wake_hit got=%h exp=01", rs_bus.req);
    end
    cycle();
    checks++;
    if (rs_bus.req !== 8'h01) begin
      failures++; $display("FAIL wake_sticky got=%h exp=01", rs_bus.req);
    end
    // Matching tag on an invalid CDB port must not wake slot 1.
    set_dispatch(6'd0, 6'd12, 1'b0, 1'b0, 2'd1);
    cdb_valid   = 2'b00;
    cdb_ptag[0] = 6'd12;
    cdb_ptag[1] = 6'd12;
    cycle();
    idle();
    #1;
    checks++;
    if (rs_bus.req !== 8'h01) begin
      failures++; $display("FAIL wake_cdb_invalid got=%h exp=01", rs_bus.req);
    end
    set_dispatch(6'd20, 6'd21, 1'b0, 1'b0, 2'd3);
    cdb_valid   = 2'b11;
    cdb_ptag[0] = 6'd20;
    cdb_ptag[1] = 6'd21;
    cycle();
    idle();
    rs_bus.raddr = 3'd2;
    #1;
    checks++;
    if (rs_bus.req !== 8'h05) begin
      failures++; $display("FAIL bypass_req got=%h exp=05", rs_bus.req);
    end
    checks++;
    if (rs_bus.rdata.meta.prs2_addr !== 6'd21) begin
      failures++; $display("FAIL bypass_rdata got=%0d exp=21", rs_bus.rdata.meta.prs2_addr);
    end
  endtask

  task automatic test_reset_midop();
    rst_n = 1'b0;
    #1;
    checks++;
    if (rs_bus.req !== 8'h00) begin
      failures++; $display("FAIL midrst_req got=%h exp=00", rs_bus.req);
    end
    checks++;
    if (rs_bus.empty !== 1'b1) begin
      failures++; $display("FAIL midrst_empty got=%b exp=1", rs_bus.empty);
    end
    checks++;
    if (rs_bus.full !== 1'b0) begin
      failures++; $display("FAIL midrst_full got=%b exp=0", rs_bus.full);
    end
    cycle();
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      set_dispatch(6'(i + 1), 6'd0, 1'b1, 1'b0, 2'd0);
      cycle();
    end
    idle();
    #1;
    checks++;
    if (rs_bus.full !== 1'b1) begin
      failures++; $display("FAIL fill_full got=%b exp=1", rs_bus.full);
    end
    checks++;
    if (rs_bus.req !== 8'hFF) begin
      failures++; $display("FAIL fill_req got=%h exp=ff", rs_bus.req);
    end
    set_dispatch(6'd33, 6'd0, 1'b1, 1'b0, 2'd0);
    rs_bus.ren   = 1'b1;
    rs_bus.raddr = 3'd3;
    cycle();
    idle();
    #1;
    checks++;
    if (rs_bus.full !== 1'b0) begin
      failures++; $display("FAIL full_issue_full got=%b exp=0", rs_bus.full);
    end
    checks++;
    if (rs_bus.req !== 8'hF7) begin
      failures++; $display("FAIL full_drop_req got=%h exp=f7", rs_bus.req);
    end
    set_dispatch(6'd44, 6'd0, 1'b1, 1'b0, 2'd0);
    cycle();
    idle();
    rs_bus.raddr = 3'd3;
    #1;
    checks++;
    if (rs_bus.full !== 1'b1) begin
      failures++; $display("FAIL refill_full got=%b exp=1", rs_bus.full);
    end
    checks++;
    if (rs_bus.rdata.meta.prs1_addr !== 6'd44) begin
      failures++; $display("FAIL refill_slot3 got=%0d exp=44", rs_bus.rdata.meta.prs1_addr);
    end
    rs_bus.raddr = 3'd2;
    #1;
    checks++;
    if (rs_bus.rdata.meta.prs1_addr !== 6'd3) begin
      failures++; $display("FAIL refill_slot2 got=%0d exp=3", rs_bus.rdata.meta.prs1_addr);
    end
  endtask

  task automatic test_flush();
    rs_bus.ren   = 1'b1;
    rs_bus.raddr = 3'd7;
    cycle();
    idle();
    #1;
    checks++;
    if (rs_bus.req !== 8'h7F) begin
      failures++; $display("FAIL preflush_req got=%h exp=7f", rs_bus.req);
    end
    set_dispatch(6'd50, 6'd0, 1'b1, 1'b0, 2'd0);
    flush        = 1'b1;
    rs_bus.ren   = 1'b1;
    rs_bus.raddr = 3'd5;
    cycle();
    idle();
    #1;
    checks++;
    if (rs_bus.empty !== 1'b1) begin
      failures++; $display("FAIL flush_empty got=%b exp=1", rs_bus.empty);
    end
    checks++;
    if (rs_bus.req !== 8'h00) begin
      failures++; $display("FAIL flush_req got=%h exp=00", rs_bus.req);
    end
    cycle();
    checks++;
    if (rs_bus.empty !== 1'b1) begin
      failures++; $display("FAIL flush_hold got=%b exp=1", rs_bus.empty);
    end
  endtask

  task automatic test_back_to_back();
    set_dispatch(6'd1, 6'd0, 1'b1, 1'b0, 2'd0);
    cycle();
    set_dispatch(6'd2, 6'd0, 1'b1, 1'b0, 2'd0);
    cycle();
    idle();
    #1;
    checks++;
    if (rs_bus.req !== 8'h03) begin
      failures++; $display("FAIL b2b_two got=%h exp=03", rs_bus.req);
    end
    set_dispatch(6'd3, 6'd0, 1'b1, 1'b0, 2'd0);
    rs_bus.ren   = 1'b1;
    rs_bus.raddr = 3'd0;
    cycle();
    idle();
    rs_bus.raddr = 3'd2;
    #1;
    checks++;
    if (rs_bus.req !== 8'h06) begin
      failures++; $display("FAIL b2b_issue_disp got=%h exp=06", rs_bus.req);
    end
    checks++;
    if (rs_bus.rdata.meta.prs1_addr !== 6'd3) begin
      failures++; $display("FAIL b2b_slot2 got=%0d exp=3", rs_bus.rdata.meta.prs1_addr);
    end
    set_dispatch(6'd4, 6'd0, 1'b1, 1'b0, 2'd0);
    cycle();
    idle();
    rs_bus.raddr = 3'd0;
    #1;
    checks++;
    if (rs_bus.req !== 8'h07) begin
      failures++; $display("FAIL b2b_reuse got=%h exp=07", rs_bus.req);
    end
    checks++;
    if (rs_bus.rdata.meta.prs1_addr !== 6'd4) begin
      failures++; $display("FAIL b2b_slot0 got=%0d exp=4", rs_bus.rdata.meta.prs1_addr);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_dispatch_ready();
    test_wakeup();
    test_reset_midop();
    test_full();
    test_flush();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
